ram_arbiter: RTL and testbench

- Shares the single byte-banked data RAM path (pu_ram + DataRAM, 4 x 8-bit lanes, 64 words) between two requesters.
  - m0 is the core load/store unit.
  - m1 is the loader/debug port.
- Round-robin arbitration with a per-requester req/ack handshake.
- Alignment and range checking happen before the RAM is touched.
- The block sits between the requesters and pu_ram and drives pu_ram's re/we/width/addr/wdata inputs.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_align_chk.sv | 40 ++++
 rtl/ram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the data RAM arbiter and its alignment checker.
//   - Access width encodings as seen on the requester and pu_ram ports.
//   - FSM state encodings for the arbiter.
//   - Default geometry of the implemented RAM.
package ram_pkg;

  // Default byte-address width and number of implemented 32-bit words.
  localparam int ADDR_W_DEF    = 32;
  localparam int MEM_WORDS_DEF = 64;

  // Access width encoding; 2'b11 is reserved and always rejected.
  typedef enum logic [1:0] {
    W_BYTE    = 2'b00,
    W_HALF    = 2'b01,
    W_WORD    = 2'b10,
    W_ILLEGAL = 2'b11
  } width_e;

  // Arbiter states: wait for a request, drive the RAM for one cycle, respond.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/ram_align_chk.sv
// ram_align_chk
// Combinational access legality check for the byte-banked data RAM.
// Ports:
//   width_i  access width (00 byte, 01 half, 10 word, 11 reserved)
//   addr_i   byte address
//   err_o    1 when the access is misaligned, uses the reserved width,
//            or touches a byte at or above MEM_WORDS*4
module ram_align_chk
  import ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic [1:0]        width_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              err_o
);

  // One extra bit so the limit is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_WORDS * 4);

  logic misaligned;
  logic outOfRange;

  // Alignment depends only on the low address bits for the chosen width;
  // the range test uses the start address, which is enough because every
  // legal access is naturally aligned and so never straddles the limit.
  always_comb begin
    misaligned = 1'b0;
    case (width_i)
      W_BYTE:  misaligned = 1'b0;
      W_HALF:  misaligned = addr_i[0];
      W_WORD:  misaligned = |addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
    outOfRange = ({1'b0, addr_i} >= LIMIT);
    err_o      = misaligned | outOfRange;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the data RAM path (pu_ram + DataRAM) between the core load/store
// unit (m0) and the loader/debug port (m1) with round-robin arbitration.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   mX_req_i                    request, held with stable fields until ack
//   mX_we_i, mX_width_i         store/load, access width
//   mX_addr_i, mX_wdata_i       byte address, right-justified store data
//   mX_ack_o                    one-cycle completion pulse
//   mX_err_o, mX_rdata_o        error flag and load data, valid with ack
//   mem_re_o, mem_we_o          RAM strobes, only ever high in ACCESS
//   mem_width_o, mem_addr_o,
//   mem_wdata_o                 registered access fields to pu_ram
//   mem_rdata_i                 combinational read data from pu_ram
//   busy_o                      high whenever the FSM is not idle
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [1:0]        m0_width_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [31:0]       m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [1:0]        m1_width_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [31:0]       m1_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_width_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic              lastGrant_q, lastGrant_d;
  logic              grantId_q, grantId_d;
  logic              we_q, we_d;
  logic [1:0]        width_q, width_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              anyReq;
  logic              winner;
  logic              selWe;
  logic [1:0]        selWidth;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selWdata;
  logic              chkErr;
  logic              inAccess;
  logic              inResp;
  logic [31:0]       respData;

  // Winner selection: a lone requester always wins; on a conflict the one
  // that was not served last goes next. The winner's fields are muxed so a
  // single checker can classify the access before it is captured.
  always_comb begin
    anyReq   = m0_req_i | m1_req_i;
    winner   = (m0_req_i & m1_req_i) ? ~lastGrant_q : m1_req_i;
    selWe    = winner ? m1_we_i    : m0_we_i;
    selWidth = winner ? m1_width_i : m0_width_i;
    selAddr  = winner ? m1_addr_i  : m0_addr_i;
    selWdata = winner ? m1_wdata_i : m0_wdata_i;
  end

  ram_align_chk #(
    .ADDR_W   (ADDR_W),
    .MEM_WORDS(MEM_WORDS)
  ) u_align_chk (
    .width_i(selWidth),
    .addr_i (selAddr),
    .err_o  (chkErr)
  );

  // State and transaction registers. Clearing the access fields on reset
  // keeps every output at zero while reset is held, and drops any access
  // that was in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      lastGrant_q <= 1'b1;
      grantId_q   <= 1'b0;
      we_q        <= 1'b0;
      width_q     <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      we_q        <= we_d;
      width_q     <= width_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic. A rejected access skips ACCESS entirely so no strobe
  // ever reaches the RAM for it.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grantId_d   = grantId_q;
    we_d        = we_q;
    width_d     = width_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (anyReq) begin
          grantId_d   = winner;
          lastGrant_d = winner;
          we_d        = selWe;
          width_d     = selWidth;
          addr_d      = selAddr;
          wdata_d     = selWdata;
          err_d       = chkErr;
          state_d     = chkErr ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          rdata_d = mem_rdata_i;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state. Response data is forced to
  // zero for stores and errors so a stale rdata_q never leaks out.
  always_comb begin
    inAccess    = (state_q == S_ACCESS);
    inResp      = (state_q == S_RESP);
    mem_re_o    = inAccess & ~we_q;
    mem_we_o    = inAccess & we_q;
    mem_width_o = width_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    respData    = (err_q | we_q) ? 32'd0 : rdata_q;
    m0_ack_o    = inResp & ~grantId_q;
    m0_err_o    = inResp & ~grantId_q & err_q;
    m0_rdata_o  = (inResp & ~grantId_q) ? respData : 32'd0;
    m1_ack_o    = inResp & grantId_q;
    m1_err_o    = inResp & grantId_q & err_q;
    m1_rdata_o  = (inResp & grantId_q) ? respData : 32'd0;
    busy_o      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter. A small pu_ram model answers the
// RAM strobes; a separate byte-array reference predicts every response.
module tb_ram_arbiter;

  localparam int MEM_WORDS = 64;

  logic        clk;
  logic        rstN;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  width [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdataOut [2];
  logic        memRe;
  logic        memWe;
  logic [1:0]  memWidth;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        busy;

  logic [31:0] ramWords [MEM_WORDS];
  logic [31:0] ramWord;
  logic [7:0]  refBytes [MEM_WORDS*4];
  int          refLastGrant;
  logic [31:0] lastRdata;
  int          checks;
  int          failures;

  ram_arbiter #(
    .ADDR_W   (32),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .m0_req_i   (req[0]),
    .m0_we_i    (we[0]),
    .m0_width_i (width[0]),
    .m0_addr_i  (addr[0]),
    .m0_wdata_i (wdata[0]),
    .m0_ack_o   (ack[0]),
    .m0_err_o   (err[0]),
    .m0_rdata_o (rdataOut[0]),
    .m1_req_i   (req[1]),
    .m1_we_i    (we[1]),
    .m1_width_i (width[1]),
    .m1_addr_i  (addr[1]),
    .m1_wdata_i (wdata[1]),
    .m1_ack_o   (ack[1]),
    .m1_err_o   (err[1]),
    .m1_rdata_o (rdataOut[1]),
    .mem_re_o   (memRe),
    .mem_we_o   (memWe),
    .mem_width_o(memWidth),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata),
    .busy_o     (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] initWord(int i);
    return (32'(i) * 32'h0104_0901) ^ 32'h5AC3_96E1;
  endfunction

  // pu_ram stand-in: 32-bit words with byte lanes, written on the clock
  // edge that ends a store strobe.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ramWords[i] = initWord(i);
    forever begin
      @(posedge clk);
      if (memWe) begin
        case (memWidth)
          2'b00:   ramWords[memAddr[7:2]][{memAddr[1:0], 3'b000} +: 8]  <= memWdata[7:0];
          2'b01:   ramWords[memAddr[7:2]][{memAddr[1], 4'b0000} +: 16] <= memWdata[15:0];
          default: ramWords[memAddr[7:2]] <= memWdata;
        endcase
      end
    end
  end

  // pu_ram read path: right-justified, zero-extended, combinational.
  always_comb begin
    ramWord  = ramWords[memAddr[7:2]];
    memRdata = 32'd0;
    case (memWidth)
      2'b00:   memRdata[7:0]  = ramWord[{memAddr[1:0], 3'b000} +: 8];
      2'b01:   memRdata[15:0] = ramWord[{memAddr[1], 4'b0000} +: 16];
      default: memRdata       = ramWord;
    endcase
  end

  // Reference rules: which requests are rejected, and what a little-endian
  // byte memory returns or absorbs for a legal access.
  function automatic logic refIsErr(logic [1:0] w, logic [31:0] a);
    return (w == 2'b11) || (w == 2'b01 && a % 2 != 0) ||
           (w == 2'b10 && a % 4 != 0) || (a >= MEM_WORDS * 4);
  endfunction

  function automatic logic [31:0] refRead(logic [31:0] a, logic [1:0] w);
    logic [31:0] r;
    int n;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    r = 32'd0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = refBytes[int'(a) + k];
    return r;
  endfunction

  task automatic refWrite(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int n;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) refBytes[int'(a) + k] = d[k*8 +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_rdata0"}, rdataOut[0], 32'd0);
    checkOutput({tag, "_rdata1"}, rdataOut[1], 32'd0);
    checkOutput({tag, "_strobes"}, 32'({memRe, memWe}), 32'd0);
    checkOutput({tag, "_mem_width"}, 32'(memWidth), 32'd0);
    checkOutput({tag, "_mem_addr"}, memAddr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, memWdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Loads one requester's fields; the request itself is raised by runTxn.
  task automatic applyStimulus(input int m, input logic w, input logic [1:0] wd,
                               input logic [31:0] a, input logic [31:0] d);
    we[m]    = w;
    width[m] = wd;
    addr[m]  = a;
    wdata[m] = d;
  endtask

  // Raises the requests in mask, predicts the service order from the
  // round-robin rule, and checks each response, its latency and the RAM
  // strobes it caused until every request has been acknowledged.
  task automatic runTxn(input logic [1:0] mask);
    int cur;
    int cyc;
    int since;
    int reCnt;
    int weCnt;
    logic [1:0] pending;
    logic bothSeen;
    logic expErr;
    logic good;
    logic [31:0] expData;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    if (mask == 2'b11) cur = (refLastGrant == 1) ? 0 : 1;
    else cur = mask[1] ? 1 : 0;
    pending  = mask;
    req      = mask;
    cyc      = 0;
    since    = 0;
    reCnt    = 0;
    weCnt    = 0;
    bothSeen = 1'b0;
    while (pending != 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      since++;
      if (memRe && memWe) bothSeen = 1'b1;
      if (memRe || memWe) begin
        checkOutput("strobe_addr", memAddr, addr[cur]);
        checkOutput("strobe_width", 32'(memWidth), 32'(width[cur]));
        if (memWe) checkOutput("strobe_wdata", memWdata, wdata[cur]);
      end
      reCnt += int'(memRe);
      weCnt += int'(memWe);
      if (ack != 2'b00) begin
        expErr  = refIsErr(width[cur], addr[cur]);
        good    = !expErr;
        expData = (good && !we[cur]) ? refRead(addr[cur], width[cur]) : 32'd0;
        checkOutput("ack_onehot", 32'(ack), 32'd1 << cur);
        checkOutput("ack_err", 32'(err[cur]), 32'(expErr));
        checkOutput("ack_rdata", rdataOut[cur], expData);
        checkOutput("other_err", 32'(err[1-cur]), 32'd0);
        checkOutput("other_rdata", rdataOut[1-cur], 32'd0);
        checkOutput("latency", 32'(since), expErr ? 32'd1 : 32'd2);
        checkOutput("re_count", 32'(reCnt), (good && !we[cur]) ? 32'd1 : 32'd0);
        checkOutput("we_count", 32'(weCnt), (good && we[cur]) ? 32'd1 : 32'd0);
        checkOutput("strobe_excl", 32'(bothSeen), 32'd0);
        if (good && we[cur]) refWrite(addr[cur], width[cur], wdata[cur]);
        lastRdata    = rdataOut[cur];
        refLastGrant = cur;
        pending[cur] = 1'b0;
        req[cur]     = 1'b0;
        cur          = 1 - cur;
        since        = -1;
        reCnt        = 0;
        weCnt        = 0;
      end
    end
    req = 2'b00;
    checkOutput("completion", 32'(pending), 32'd0);
  endtask

  function automatic logic [1:0] randWidth();
    if ($urandom_range(0, 7) == 0) return 2'b11;
    return 2'($urandom_range(0, 2));
  endfunction

  function automatic logic [31:0] randAddr(logic [1:0] w);
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'(256 + $urandom_range(0, 4000));
    a = 32'($urandom_range(0, 255));
    if (r < 8) begin
      if (w == 2'b01) a[0] = 1'b0;
      if (w == 2'b10) a[1:0] = 2'b00;
    end
    return a;
  endfunction

  initial begin
    checks       = 0;
    failures     = 0;
    refLastGrant = 1;
    lastRdata    = 32'd0;
    rstN         = 1'b0;
    req          = 2'b00;
    for (int m = 0; m < 2; m++) applyStimulus(m, 1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < MEM_WORDS; i++) begin
      for (int k = 0; k < 4; k++) refBytes[i*4 + k] = initWord(i) >> (k * 8);
    end

    // Power-on reset state.
    #2;
    checkIdleOutputs("por");
    @(negedge clk);
    rstN = 1'b1;

    // First conflict after reset goes to m0, then m1 completes its store.
    applyStimulus(0, 1'b0, 2'b10, 32'd0, 32'd0);
    applyStimulus(1, 1'b1, 2'b10, 32'd4, 32'hAABB_CCDD);
    runTxn(2'b11);

    // Word store then word load at address 12.
    applyStimulus(0, 1'b1, 2'b10, 32'd12, 32'h0102_0304);
    runTxn(2'b01);
    applyStimulus(0, 1'b0, 2'b10, 32'd12, 32'd0);
    runTxn(2'b01);
    checkOutput("load12_value", lastRdata, 32'h0102_0304);

    // m0 was served last, so this conflict goes to m1 first.
    applyStimulus(0, 1'b0, 2'b10, 32'd4, 32'd0);
    applyStimulus(1, 1'b0, 2'b10, 32'd12, 32'd0);
    runTxn(2'b11);
    checkOutput("pair2_m0_load4", lastRdata, 32'hAABB_CCDD);

    // Rejected accesses: misaligned half, misaligned word, reserved width,
    // and the first byte past the implemented RAM.
    applyStimulus(0, 1'b0, 2'b01, 32'd5, 32'd0);
    runTxn(2'b01);
    applyStimulus(1, 1'b0, 2'b10, 32'd6, 32'd0);
    runTxn(2'b10);
    applyStimulus(0, 1'b0, 2'b11, 32'd0, 32'd0);
    runTxn(2'b01);
    applyStimulus(0, 1'b0, 2'b10, 32'd256, 32'd0);
    runTxn(2'b01);

    // Byte store lands in the top lane of word 0.
    applyStimulus(0, 1'b1, 2'b00, 32'd3, 32'h0000_00EE);
    runTxn(2'b01);
    applyStimulus(0, 1'b0, 2'b10, 32'd0, 32'd0);
    runTxn(2'b01);
    checkOutput("byte_lane_top", 32'(lastRdata[31:24]), 32'h0000_00EE);

    // Randomised singles and conflicts.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] w0;
      logic [1:0] w1;
      w0 = randWidth();
      w1 = randWidth();
      applyStimulus(0, 1'($urandom_range(0, 1)), w0, randAddr(w0), $urandom);
      applyStimulus(1, 1'($urandom_range(0, 1)), w1, randAddr(w1), $urandom);
      runTxn(2'($urandom_range(1, 3)));
    end

    // Reset while an m1 store is in ACCESS: it must vanish without an ack
    // or a RAM write, and m0 must win the next conflict.
    @(negedge clk);
    applyStimulus(1, 1'b1, 2'b10, 32'd8, 32'h5566_7788);
    req = 2'b10;
    @(negedge clk);
    checkOutput("pre_reset_we", 32'(memWe), 32'd1);
    rstN = 1'b0;
    req  = 2'b00;
    #1;
    checkIdleOutputs("async_reset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_no_ack", 32'(ack), 32'd0);
    end
    rstN         = 1'b1;
    refLastGrant = 1;
    applyStimulus(0, 1'b0, 2'b10, 32'd8, 32'd0);
    applyStimulus(1, 1'b0, 2'b10, 32'd8, 32'd0);
    runTxn(2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
